// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the RV32I store buffer: datapath widths,
// store funct3 encodings, the FIFO entry layout and the drain FSM states.
package store_buffer_pkg;

    localparam int MSB = 31;
    localparam int LSB = 0;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // Only the word address is kept; byte position lives in the lane mask.
    typedef struct packed {
        logic [MSB:2]   addr;
        logic [MSB:LSB] wdata;
        logic [3:0]     we;
    } store_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } sb_state_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational SB/SH/SW decode: byte-lane write enables, replicated write
// data, a legal-opcode flag and a misalignment flag for the store buffer.
module store_lane_align
    import store_buffer_pkg::*;
(
    input  logic [2:0]     funct3_i,
    input  logic [1:0]     addr_lo_i,
    input  logic [MSB:LSB] data_i,
    output logic [3:0]     we_o,
    output logic [MSB:LSB] wdata_o,
    output logic           valid_op_o,
    output logic           misaligned_o
);

    // Halfword masks shifted past lane 3 are truncated, not wrapped.
    always_comb begin
        we_o         = 4'b0000;
        wdata_o      = '0;
        valid_op_o   = 1'b0;
        misaligned_o = 1'b0;
        case (funct3_i)
            F3_SB: begin
                we_o       = 4'b0001 << addr_lo_i;
                wdata_o    = {4{data_i[7:0]}};
                valid_op_o = 1'b1;
            end
            F3_SH: begin
                we_o         = 4'b0011 << addr_lo_i;
                wdata_o      = {2{data_i[15:0]}};
                valid_op_o   = 1'b1;
                misaligned_o = addr_lo_i[0];
            end
            F3_SW: begin
                we_o         = 4'b1111;
                wdata_o      = data_i;
                valid_op_o   = 1'b1;
                misaligned_o = |addr_lo_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// RV32I store buffer: lane-aligned FIFO of stores drained to data memory,
// with load-hazard probe and fence drain. Define MISALIGN_TRAP_EN to reject misaligned stores.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [2:0]                 st_funct3,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_data,
    output logic                       dm_valid,
    input  logic                       dm_ready,
    output logic [31:0]                dm_addr,
    output logic [31:0]                dm_wdata,
    output logic [3:0]                 dm_we,
    input  logic [31:0]                ld_addr,
    output logic                       ld_hazard,
    input  logic                       fence_req,
    output logic                       fence_done,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       misalign
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

    store_entry_t    mem_q [DEPTH];
    logic [PTRW-1:0] head_q;
    logic [PTRW-1:0] tail_q;
    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;
    sb_state_t       state_q;
    sb_state_t       state_d;
    logic            fence_done_q;
    logic            fence_done_d;
    logic            misalign_q;
    logic            misalign_d;

    logic [3:0]      lane_we;
    logic [31:0]     lane_wdata;
    logic            lane_valid;
    logic            lane_misaligned;
    logic            reject;
    logic            st_fire;
    logic            enq;
    logic            deq;
    store_entry_t    head_entry;

    store_lane_align u_align (
        .funct3_i     (st_funct3),
        .addr_lo_i    (st_addr[1:0]),
        .data_i       (st_data),
        .we_o         (lane_we),
        .wdata_o      (lane_wdata),
        .valid_op_o   (lane_valid),
        .misaligned_o (lane_misaligned)
    );

`ifdef MISALIGN_TRAP_EN
    assign reject = lane_misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = lane_misaligned;
    assign reject            = 1'b0;
`endif

    logic unused_ld_lo;
    assign unused_ld_lo = ^ld_addr[1:0];

    assign st_ready = (count_q < FULL) && (state_q == RUN);
    assign dm_valid = (count_q != '0);
    assign st_fire  = st_valid && st_ready;
    // Illegal opcodes and trapped stores still complete the handshake.
    assign enq      = st_fire && lane_valid && !reject;
    assign deq      = dm_valid && dm_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (enq) begin
            mem_q[tail_q] <= '{addr: st_addr[31:2], wdata: lane_wdata, we: lane_we};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            state_q      <= RUN;
            fence_done_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            if (enq) begin
                tail_q <= tail_q + 1'b1;
            end
            if (deq) begin
                head_q <= head_q + 1'b1;
            end
            count_q      <= count_d;
            state_q      <= state_d;
            fence_done_q <= fence_done_d;
            misalign_q   <= misalign_d;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    assign misalign_d = st_fire && lane_valid && reject;

    // Leaving DRAIN on the edge that empties the buffer makes fence_done
    // coincide with the first RUN cycle.
    always_comb begin
        state_d      = state_q;
        fence_done_d = 1'b0;
        case (state_q)
            RUN: begin
                if (fence_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (count_d == '0) begin
                    state_d      = RUN;
                    fence_done_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign head_entry = mem_q[head_q];
    assign dm_addr    = dm_valid ? {head_entry.addr, 2'b00} : 32'h0;
    assign dm_wdata   = dm_valid ? head_entry.wdata : 32'h0;
    assign dm_we      = dm_valid ? head_entry.we : 4'b0000;

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        logic [PTRW-1:0] off;
        ld_hazard = 1'b0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTRW'(i) - head_q;
            if ((CNTW'(off) < count_q) && (mem_q[i].addr == ld_addr[31:2])) begin
                ld_hazard = 1'b1;
            end
        end
    end

    assign count      = count_q;
    assign fence_done = fence_done_q;
    assign misalign   = misalign_q;

endmodule

// File: doc/store_buffer.md
# store_buffer

Store buffer between the execute stage and data memory of the RV32I core. Accepts decoded stores from execute and computes byte-lane write enables and lane-aligned write data, using the same SB/SH/SW strobe rules as the execute-stage store decode. Queues stores in a small FIFO and drains them to the data-memory port under a valid/ready handshake. Also provides a load-hazard probe and a fence drain so loads never observe stale memory.

## Interface
- DEPTH, 4, number of buffered stores (power of two, ≥2)
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  execute presents a store this cycle
- st_ready  out  1  buffer accepts a store this cycle
- st_funct3  in  3  store funct3 (SB/SH/SW)
- st_addr  in  32  byte address
- st_data  in  32  raw rs2 value
- dm_valid  out  1  head entry presented to data memory
- dm_ready  in  1  data memory takes the head entry this cycle
- dm_addr  out  32  word address of head entry, bits [1:0] = 0
- dm_wdata  out  32  lane-aligned write data
- dm_we  out  4  byte write enables
- ld_addr  in  32  address of the load in execute
- ld_hazard  out  1  a buffered store targets the same word as ld_addr
- fence_req  in  1  single-cycle request to drain all stores
- fence_done  out  1  single-cycle pulse when the drain completes
- count  out  $clog2(DEPTH+1)  occupied entries
- misalign  out  1  one-cycle pulse for a rejected misaligned store (tied 0 without MISALIGN_TRAP_EN)

## Operation
- Enqueue: on each edge where st_valid && st_ready, write the entry at tail.
  - SB: we = 4'b0001 << a[1:0], wdata = {4{d[7:0]}}.
  - SH: we = 4'b0011 << a[1:0], truncated to 4 bits; wdata = {2{d[15:0]}}.
  - SW: we = 4'b1111, wdata = d.
  - Entry address = {a[31:2], 2'b00}.
- Invalid funct3: handshake completes, nothing is enqueued, count is unchanged.
- st_ready = (count < DEPTH) && state == RUN. It does not depend on dm_ready, so there is no combinational pass-through.
- Dequeue: dm_valid = (count != 0). On each edge where dm_valid && dm_ready, advance head.
- dm_addr, dm_wdata and dm_we come from the head entry. They stay stable while dm_valid && !dm_ready.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- ld_hazard is combinational: OR over the valid entries of (entry addr[31:2] == ld_addr[31:2]). It is 0 when the buffer is empty.
- FSM, two states:
  - RUN → DRAIN when fence_req is high. Any store accepted in the same cycle is still enqueued.
  - DRAIN holds st_ready at 0.
  - DRAIN → RUN when count reaches 0. fence_done pulses for one cycle in the first RUN cycle.
  - fence_req while already in DRAIN is ignored.
  - fence_req with an empty buffer: DRAIN for one cycle, then fence_done.
- Reset, asynchronous and taking effect mid-operation:
  - Pointers and count go to 0; state goes to RUN.
  - All buffered stores are discarded.
  - Outputs: dm_valid=0, dm_addr=0, dm_wdata=0, dm_we=0, st_ready=1, ld_hazard=0, fence_done=0, misalign=0, count=0.

## Timing
- Enqueue-to-memory latency is 1 cycle minimum: a store accepted at edge N gives dm_valid=1 after edge N.
- Full-throughput draining at one store per cycle when dm_ready is held high.
- count, the pointers, state, fence_done and misalign are registered.
- st_ready and dm_valid are decoded from registers only.
- ld_hazard and the dm_* data outputs are combinational from registered state (plus ld_addr for ld_hazard).

## Configuration
- MISALIGN_TRAP_EN defined: a misaligned store is rejected. Misaligned means SH with a[0]=1, or SW with a[1:0]≠0.
  - Rejection: the handshake completes, nothing is enqueued, and misalign pulses high for the cycle after acceptance.
- MISALIGN_TRAP_EN undefined: misaligned stores are enqueued.
  - SH keeps its truncated mask.
  - SW uses the word address with we=4'b1111.
  - misalign is tied to 0.

## Structure
- Package parameters holds:
  - MSB/LSB.
  - The SB/SH/SW funct3 constants.
  - A new store_entry_t struct {addr[31:2], wdata[31:0], we[3:0]}.
  - A new sb_state_t enum {RUN, DRAIN}.
- One sub-module, store_lane_align: combinational funct3/addr/data → we, wdata, valid_op, misaligned.
- The FIFO storage, pointers and FSM stay in store_buffer.

## Test plan
- Basic store: SB addr 0x1003, data 0xA5 → next cycle dm_valid=1, dm_addr=0x1000, dm_we=4'b1000, dm_wdata=0xA5A5A5A5.
- Fill to full with dm_ready=0:
  - 4 SWs → count=4, st_ready=0.
  - Raise dm_ready → 4 beats drain in FIFO order, then dm_valid=0.
- Simultaneous enqueue and dequeue at count=2 for 8 cycles → count stays 2 and pointers wrap correctly.
- Hazard probe: buffered SH to 0x2002 with ld_addr=0x2000 → ld_hazard=1; with ld_addr=0x2004 → ld_hazard=0.
- Fence:
  - fence_req with 3 entries and dm_ready toggling → st_ready=0 until empty, then one fence_done pulse.
  - Reset asserted mid-drain → all outputs at reset values immediately.
- Misalign:
  - SW to 0x3002 with MISALIGN_TRAP_EN → misalign pulse, count=0.
  - The same store without the macro → dm_addr=0x3000, dm_we=4'b1111.
